// File: rtl/reg_bank.sv
// 32-entry register file with two combinational read ports, a debug read port,
// optional write-to-read forwarding and a committed-write counter.
module reg_bank #(
  parameter int unsigned      DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(227),
  parameter bit               BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [4:0]        dbg_reg,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       write_count,
  output logic [4:0]        last_written
);

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SP_ADDR  = 29;

  logic [DATA_W-1:0] regFile [NUM_REGS];
  logic              commit;
  logic              bypassHit1;
  logic              bypassHit2;

  // Address 0 is hardwired to zero, so writes there are not commits.
  assign commit = reg_write && (write_reg != '0);

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regFile[ADDR_W'(i)] <= (i == SP_ADDR) ? SP_INIT : '0;
      end
      write_count  <= '0;
      last_written <= '0;
    end else if (commit) begin
      regFile[write_reg] <= write_data;
      write_count        <= write_count + CNT_W'(1);
      last_written       <= write_reg;
    end
  end

  // Forwarding is held off during reset so reads show the reset contents.
  always_comb begin
    bypassHit1 = 1'b0;
    bypassHit2 = 1'b0;
    if (BYPASS && reset && commit) begin
      bypassHit1 = (write_reg == read_reg1);
      bypassHit2 = (write_reg == read_reg2);
    end
  end

  assign read_data1 = bypassHit1 ? write_data : regFile[read_reg1];
  assign read_data2 = bypassHit2 ? write_data : regFile[read_reg2];
  assign dbg_data   = regFile[dbg_reg];

endmodule
